// File: rtl/cnn_mem_arbiter.sv
// rtl/cnn_mem_arbiter.sv - round-robin multi-channel arbiter onto one word-addressed memory port
//
// Purpose: latches one request at a time from N_CH requesters, holds the memory
// strobe/address/data stable until mem_ready_i (or a wait timeout), then returns
// read data and a done/err pulse to the winning channel.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i/req_we_i [N_CH]        per-channel request and write select
//   req_addr_i  [N_CH*ADDR_W]    per-channel address, slice [i*ADDR_W +: ADDR_W]
//   req_wdata_i [N_CH*DATA_W]    per-channel write data, slice [i*DATA_W +: DATA_W]
//   gnt_o/done_o/err_o [N_CH]    one-cycle pulses: latched / finished / timed out
//   rdata_o                      last successful read data (held)
//   busy_o                       transaction outstanding
//   mem_req_o, write_en_o        memory strobes
//   address_o, to_memory_o       memory address and write data
//   mem_ready_i, from_memory_i   memory completion and read data
module cnn_mem_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int N_CH    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH-1:0]          req_we_i,
  input  logic [N_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [N_CH*DATA_W-1:0]   req_wdata_i,
  output logic [N_CH-1:0]          gnt_o,
  output logic [N_CH-1:0]          done_o,
  output logic [N_CH-1:0]          err_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     busy_o,
  output logic                     mem_req_o,
  output logic                     write_en_o,
  output logic [ADDR_W-1:0]        address_o,
  output logic [DATA_W-1:0]        to_memory_o,
  input  logic                     mem_ready_i,
  input  logic [DATA_W-1:0]        from_memory_i
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CH_W-1:0]  LAST_RST = CH_W'(N_CH - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CH-1:0]     gnt_q, gnt_d;
  logic [N_CH-1:0]     done_q, done_d;
  logic [N_CH-1:0]     err_q, err_d;

  logic                win_found;
  logic [CH_W-1:0]     win_ch;
  logic [CH_W-1:0]     idx;
  logic                timeout_hit;

  // Round-robin search: start one past the last winner, first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    idx       = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = CH_W'((int'(last_q) + 1 + k) % N_CH);
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_ch    = idx;
      end
    end
  end

  // mem_ready_i on the final wait edge takes priority over the timeout.
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST) && !mem_ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (win_found) state_d = BUSY;
      BUSY: if (mem_ready_i || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    gnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    last_d  = last_q;
    ch_d    = ch_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = N_CH'(1) << win_ch;
          last_d  = win_ch;
          ch_d    = win_ch;
          we_d    = req_we_i[win_ch];
          addr_d  = req_addr_i[win_ch*ADDR_W +: ADDR_W];
          wdata_d = req_wdata_i[win_ch*DATA_W +: DATA_W];
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          done_d = N_CH'(1) << ch_q;
          if (!we_q) rdata_d = from_memory_i;
        end else if (timeout_hit) begin
          done_d = N_CH'(1) << ch_q;
          err_d  = N_CH'(1) << ch_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      last_q  <= LAST_RST;
      ch_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-side outputs come straight from registers; write_en drops in IDLE.
  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state_q == BUSY);
  assign mem_req_o   = (state_q == BUSY);
  assign write_en_o  = (state_q == BUSY) && we_q;
  assign address_o   = addr_q;
  assign to_memory_o = wdata_q;

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
// tb/tb_cnn_mem_arbiter.sv - scoreboard bench for cnn_mem_arbiter
module tb_cnn_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int NC = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NC-1:0]     req, req_we, gnt, done, err;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  req_wdata;
  logic [DW-1:0]     rdata, to_memory, from_memory;
  logic [AW-1:0]     address;
  logic              busy, mem_req, write_en, mem_ready;

  logic [NC-1:0]     b_req, b_req_we, b_gnt, b_done, b_err;
  logic [NC*AW-1:0]  b_req_addr;
  logic [NC*DW-1:0]  b_req_wdata;
  logic [DW-1:0]     b_rdata, b_to_memory, b_from_memory;
  logic [AW-1:0]     b_address;
  logic              b_busy, b_mem_req, b_write_en, b_mem_ready;

  cnn_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NC), .TIMEOUT(TO)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata), .busy_o(busy),
    .mem_req_o(mem_req), .write_en_o(write_en), .address_o(address),
    .to_memory_o(to_memory), .mem_ready_i(mem_ready), .from_memory_i(from_memory)
  );

  cnn_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NC), .TIMEOUT(0)) u_dut_nto (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .gnt_o(b_gnt), .done_o(b_done), .err_o(b_err), .rdata_o(b_rdata), .busy_o(b_busy),
    .mem_req_o(b_mem_req), .write_en_o(b_write_en), .address_o(b_address),
    .to_memory_o(b_to_memory), .mem_ready_i(b_mem_ready), .from_memory_i(b_from_memory)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          ch;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_done_q[$];
  int          exp_gnt_q[$];
  logic [15:0] model_rdata;

  // Scoreboard: every gnt/done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
        else begin
          int c;
          c = exp_gnt_q.pop_front();
          check("gnt_ch", 32'(gnt), 32'd1 << c);
        end
      end
      if (done != '0) begin
        if (exp_done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
        else begin
          exp_t e;
          e = exp_done_q.pop_front();
          check("done_ch", 32'(done), 32'd1 << e.ch);
          check("err", 32'(err), e.err ? (32'd1 << e.ch) : 32'd0);
          check("rdata", 32'(rdata), 32'(e.rdata));
        end
      end else if (err != '0) begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  task automatic txn(input int ch, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input int waits, input bit ready,
                     input logic [DW-1:0] rv);
    exp_t e;
    @(negedge clk);
    req[ch] = 1'b1;
    req_we[ch] = we;
    req_addr[ch*AW +: AW] = a;
    req_wdata[ch*DW +: DW] = wd;
    exp_gnt_q.push_back(ch);
    e.ch    = ch;
    e.err   = !ready;
    e.rdata = (we || !ready) ? model_rdata : rv;
    model_rdata = e.rdata;
    exp_done_q.push_back(e);
    @(negedge clk);
    req[ch] = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check("mem_req_busy", 32'(mem_req), 32'd1);
      check("address", 32'(address), 32'(a));
      check("write_en", 32'(write_en), 32'(we));
      if (we) check("to_memory", 32'(to_memory), 32'(wd));
      if (ready && i == waits) begin
        mem_ready = 1'b1;
        from_memory = rv;
      end
      @(negedge clk);
    end
    check("mem_req_end", 32'(mem_req), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("write_en_end", 32'(write_en), 32'd0);
    check("address_hold", 32'(address), 32'(a));
    mem_ready = 1'b0;
  endtask

  logic seen_done;

  initial begin
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; from_memory = '0;
    b_req = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0;
    b_mem_ready = 1'b0; b_from_memory = '0;
    model_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {gnt, done, err, busy, mem_req, write_en}, 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_to_memory", 32'(to_memory), 32'd0);
    rst = 1'b0;

    // Zero-wait read, write with 3 waits, timeout, ready on the final wait edge.
    txn(1, 1'b0, 12'h0A5, 16'h0000, 0, 1'b1, 16'hBEEF);
    txn(0, 1'b1, 12'hFFF, 16'h1234, 3, 1'b1, 16'hDEAD);
    txn(2, 1'b0, 12'h123, 16'h0000, TO - 1, 1'b0, 16'h9999);
    txn(1, 1'b0, 12'h456, 16'h0000, TO - 1, 1'b1, 16'hCAFE);

    // Reset in the middle of a transaction.
    @(negedge clk);
    req[1] = 1'b1; req_we[1] = 1'b1; req_addr[AW +: AW] = 12'h777; req_wdata[DW +: DW] = 16'h5555;
    exp_gnt_q.push_back(1);
    @(negedge clk);
    req[1] = 1'b0;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_strobes", {gnt, done, err, busy, mem_req, write_en}, 32'd0);
    check("async_rst_address", 32'(address), 32'd0);
    check("async_rst_to_memory", 32'(to_memory), 32'd0);
    check("async_rst_rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;

    // Channels 0 and 2 together after reset: 0 first, then 2.
    @(negedge clk);
    req_we = '0;
    req[0] = 1'b1; req[2] = 1'b1;
    exp_gnt_q.push_back(0);
    @(negedge clk);
    req[0] = 1'b0;
    mem_ready = 1'b1; from_memory = 16'h0F0F;
    exp_done_q.push_back('{ch: 0, err: 1'b0, rdata: 16'h0F0F});
    @(negedge clk);
    mem_ready = 1'b0;
    exp_gnt_q.push_back(2);
    @(negedge clk);
    req[2] = 1'b0;
    mem_ready = 1'b1; from_memory = 16'h7777;
    exp_done_q.push_back('{ch: 2, err: 1'b0, rdata: 16'h7777});
    @(negedge clk);
    mem_ready = 1'b0;
    model_rdata = 16'h7777;

    // Fairness: all channels requesting continuously, memory always ready.
    @(negedge clk);
    from_memory = 16'h5A5A;
    mem_ready = 1'b1;
    req_we = '0;
    req = 3'b111;
    for (int j = 0; j < 6; j++) begin
      exp_gnt_q.push_back(j % NC);
      exp_done_q.push_back('{ch: j % NC, err: 1'b0, rdata: 16'h5A5A});
    end
    repeat (11) @(negedge clk);
    req = '0;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Timeout disabled: stays busy indefinitely, then completes normally.
    @(negedge clk);
    b_req[0] = 1'b1; b_req_addr[0 +: AW] = 12'h321;
    @(negedge clk);
    b_req[0] = 1'b0;
    check("nto_gnt", 32'(b_gnt), 32'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (b_done != '0 || b_err != '0) seen_done = 1'b1;
    end
    check("nto_no_done", 32'(seen_done), 32'd0);
    check("nto_busy", 32'(b_busy), 32'd1);
    check("nto_mem_req", 32'(b_mem_req), 32'd1);
    b_mem_ready = 1'b1; b_from_memory = 16'hD00D;
    @(negedge clk);
    b_mem_ready = 1'b0;
    check("nto_done", 32'(b_done), 32'd1);
    check("nto_err", 32'(b_err), 32'd0);
    check("nto_rdata", 32'(b_rdata), 32'hD00D);
    check("nto_busy_end", 32'(b_busy), 32'd0);

    repeat (2) @(negedge clk);
    check("gnt_queue_drained", exp_gnt_q.size(), 32'd0);
    check("done_queue_drained", exp_done_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_mem_arbiter.md
# cnn_mem_arbiter

Parametrised multi-channel memory port for the CNN-16 core family. It arbitrates N_CH independent requesters (instruction fetch, data path, DMA-style feature-map loaders) onto a single word-addressed memory with a `mem_ready` handshake. It latches one request at a time, drives address, data and strobes stable until memory answers, and returns read data and completion or timeout status to the winning channel. It sits between the core/accelerator masters and the shared memory, replacing the single-master direct memory hookup of the 16-bit top.

## Interface
Parameters:
- DATA_W, 16, memory word width
- ADDR_W, 12, memory address width
- N_CH, 3, number of requesting channels (≥1)
- TIMEOUT, 255, max BUSY cycles without `mem_ready` before abort; 0 disables timeout

Ports (channel i occupies bit i, or slice [i*W +: W] of flattened buses):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_CH  request per channel, held until gnt
- req_we  in  N_CH  1 = write, 0 = read
- req_addr  in  N_CH*ADDR_W  request address
- req_wdata  in  N_CH*DATA_W  write data
- gnt  out  N_CH  one-cycle pulse: request latched
- done  out  N_CH  one-cycle pulse: transaction finished (ok or error)
- err  out  N_CH  one-cycle pulse coincident with done on timeout
- rdata  out  DATA_W  read data, valid in done cycle of a successful read, held after
- busy  out  1  high while a transaction is outstanding
- mem_req  out  1  memory strobe
- write_en  out  1  memory write strobe, only with mem_req
- address  out  ADDR_W  memory address
- to_memory  out  DATA_W  memory write data
- mem_ready  in  1  memory has completed the current access
- from_memory  in  DATA_W  memory read data, valid when mem_ready high

## Operation
- FSM states: IDLE, BUSY. Reset → IDLE.
- IDLE: if any req bit high at the edge, grant channel by round-robin: search starts at (last+1) mod N_CH, first set bit wins; `last` ← winner. Latch we/addr/wdata of winner; → BUSY. No req → stay IDLE.
- BUSY: mem_req=1, address/to_memory/write_en driven from latched values, stable for the whole state. Wait counter increments each BUSY edge without mem_ready.
- mem_ready high at an edge in BUSY: rdata ← from_memory (reads only; writes leave rdata unchanged), done[ch] pulse, → IDLE.
- Timeout: counter == TIMEOUT−1 at an edge with mem_ready low (TIMEOUT>0) → done[ch] and err[ch] pulse, rdata unchanged, → IDLE. mem_ready high on that same edge wins: normal completion, no err.
- req sampled only in IDLE; mem_ready ignored in IDLE.
- Reset pointer `last` = N_CH−1, so channel 0 has first priority.
- Counter width clog2(TIMEOUT+1), min 1; clears on entering BUSY.

## Timing
- Reset values: gnt=0, done=0, err=0, rdata=0, busy=0, mem_req=0, write_en=0, address=0, to_memory=0. Reset asserted mid-transaction drops all strobes immediately (asynchronous), discards the transaction without done/err, and restores `last`.
- All outputs registered.
- req seen at edge k → cycle after k: gnt pulse, busy=1, mem_req=1, address valid.
- mem_ready high at edge k+1+w (w wait cycles) → next cycle: done (+rdata), mem_req=0, busy=0.
- Min transaction: 2 cycles (1 grant/strobe cycle + 1 completion cycle); back-to-back throughput 1 transaction per 2+w cycles.
- Timeout transaction: mem_req high exactly TIMEOUT cycles.
- Requester must drop req after seeing gnt, before the next IDLE sample; a req still high then is treated as a new request.
- address, to_memory, write_en: hold last values in IDLE except write_en=0.

## Test plan
- Reset: assert rst mid-BUSY with mem_req=1 → all outputs 0 in the same cycle, no done; after release, req[2] and req[0] both high → channel 0 granted first.
- Zero-wait read ch1: addr 0x0A5, mem_ready tied high, from_memory 0xBEEF → gnt[1] at cycle+1, done[1] at cycle+2, rdata=0xBEEF, err=0, mem_req high exactly 1 cycle.
- Write ch0 with 3 wait states: addr 0xFFF, wdata 0x1234 → write_en=1, address=0xFFF, to_memory=0x1234 stable for 4 cycles; done[0], rdata unchanged.
- Fairness: all 3 channels request continuously (re-asserting after gnt) → grant order 0,1,2,0,1,2; no channel granted twice before the others.
- Timeout: TIMEOUT=4, mem_ready held low → mem_req high 4 cycles, done and err pulse on the winning channel, rdata unchanged; mem_ready rising on the 4th edge → done without err.
- TIMEOUT=0: mem_ready low for 1000 cycles → stays BUSY; completes when mem_ready rises.
